// File: rtl/vin_bus_master.sv
// Initiator for the EF9340/EF9341 internal bus: runs one command at a time
// through SETUP/STROBE/HOLD/GAP and returns sampled bus data with a done pulse.
module vin_bus_master #(
  parameter int SETUP_CYC  = 1,
  parameter int STROBE_CYC = 3,
  parameter int HOLD_CYC   = 1,
  parameter int GAP_CYC    = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       req_valid,
  output logic       req_ready,
  input  logic [2:0] req_cmd,
  input  logic [7:0] req_a,
  input  logic [7:0] req_b,
  input  logic [3:0] req_adr,
  output logic       done,
  output logic       err,
  output logic [7:0] rdata_a,
  output logic [7:0] rdata_b,
  output logic       gen_busy,
  inout  wire  [7:0] busA,
  inout  wire  [7:0] busB,
  output logic       r_wi,
  output logic       sm_n,
  output logic       sg_n,
  output logic       st_n,
  output logic [3:0] adr,
  input  logic       ve_n
);

  typedef enum logic [2:0] {
    S_IDLE, S_SETUP, S_STROBE, S_HOLD, S_GAP
  } state_t;

  typedef enum logic [2:0] {
    CMD_CHAR     = 3'd0,
    CMD_SLICE    = 3'd1,
    CMD_MBX_RD   = 3'd2,
    CMD_MBX_WR_M = 3'd3,
    CMD_MBX_WR_G = 3'd4
  } cmd_t;

  state_t     r_state;
  cmd_t       r_cmd;
  logic [3:0] r_cnt;
  logic       r_done, r_err;
  logic [7:0] r_rdata_a, r_rdata_b;
  logic       r_rw, r_sm_n, r_sg_n, r_st_n;
  logic [3:0] r_adr;
  logic       r_drv;
  logic [7:0] r_bus_a, r_bus_b;
  logic       r_ve_meta, r_gen_busy;

  // The bus drive enable is a flop, so release lines up exactly with the
  // registered strobes and never glitches onto a cycle the GEN may own.
  assign busA = r_drv ? r_bus_a : 8'hzz;
  assign busB = r_drv ? r_bus_b : 8'hzz;

  assign req_ready = (r_state == S_IDLE);
  assign done      = r_done;
  assign err       = r_err;
  assign rdata_a   = r_rdata_a;
  assign rdata_b   = r_rdata_b;
  assign gen_busy  = r_gen_busy;
  assign r_wi      = r_rw;
  assign sm_n      = r_sm_n;
  assign sg_n      = r_sg_n;
  assign st_n      = r_st_n;
  assign adr       = r_adr;

  // NOTE: sequential state uses non-blocking assignments only, so every flop
  // samples pre-edge values regardless of statement order within the block.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_ve_meta  <= 1'b0;
      r_gen_busy <= 1'b0;
    end else begin
      r_ve_meta  <= ~ve_n;
      r_gen_busy <= r_ve_meta;
    end
  end

  // NOTE: reset is synchronous; an aborted command simply loses its state,
  // and the done pulse is cleared along with everything else.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= S_IDLE;
      r_cmd     <= CMD_CHAR;
      r_cnt     <= 4'd0;
      r_done    <= 1'b0;
      r_err     <= 1'b0;
      r_rdata_a <= 8'h00;
      r_rdata_b <= 8'h00;
      r_rw      <= 1'b1;
      r_sm_n    <= 1'b1;
      r_sg_n    <= 1'b1;
      r_st_n    <= 1'b1;
      r_adr     <= 4'd0;
      r_drv     <= 1'b0;
      r_bus_a   <= 8'h00;
      r_bus_b   <= 8'h00;
    end else begin
      r_done <= 1'b0;
      r_err  <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (req_valid) begin
            r_bus_a <= req_a;
            r_bus_b <= req_b;
            if (req_cmd > 3'd4) begin
              r_state <= S_GAP;
              r_cnt   <= 4'(GAP_CYC - 1);
              r_done  <= 1'b1;
              r_err   <= 1'b1;
            end else begin
              r_cmd   <= cmd_t'(req_cmd);
              r_state <= S_SETUP;
              r_cnt   <= 4'(SETUP_CYC - 1);
              r_rw    <= (req_cmd != CMD_MBX_RD);
              r_st_n  <= (req_cmd == CMD_CHAR) || (req_cmd == CMD_SLICE);
              r_adr   <= (req_cmd == CMD_SLICE) ? req_adr : 4'd0;
              r_drv   <= (req_cmd == CMD_CHAR) || (req_cmd == CMD_MBX_WR_M) ||
                         (req_cmd == CMD_MBX_WR_G);
            end
          end
        end
        S_SETUP: begin
          if (r_cnt == 4'd0) begin
            r_state <= S_STROBE;
            r_cnt   <= 4'(STROBE_CYC - 1);
            r_sm_n  <= !((r_cmd == CMD_CHAR) || (r_cmd == CMD_MBX_WR_M));
            r_sg_n  <= !((r_cmd == CMD_SLICE) || (r_cmd == CMD_MBX_WR_G));
          end else begin
            r_cnt <= r_cnt - 4'd1;
          end
        end
        S_STROBE: begin
          if (r_cnt == 4'd0) begin
            // Last low clock: the GEN output has been stable since the 2nd one.
            if (r_cmd == CMD_SLICE || r_cmd == CMD_MBX_RD) r_rdata_a <= busA;
            if (r_cmd == CMD_MBX_RD) r_rdata_b <= busB;
            r_state <= S_HOLD;
            r_cnt   <= 4'(HOLD_CYC - 1);
            r_sm_n  <= 1'b1;
            r_sg_n  <= 1'b1;
          end else begin
            r_cnt <= r_cnt - 4'd1;
          end
        end
        S_HOLD: begin
          if (r_cnt == 4'd0) begin
            r_state <= S_GAP;
            r_cnt   <= 4'(GAP_CYC - 1);
            r_done  <= 1'b1;
            r_rw    <= 1'b1;
            r_st_n  <= 1'b1;
            r_adr   <= 4'd0;
            r_drv   <= 1'b0;
          end else begin
            r_cnt <= r_cnt - 4'd1;
          end
        end
        S_GAP: begin
          if (r_cnt == 4'd0) r_state <= S_IDLE;
          else               r_cnt   <= r_cnt - 4'd1;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_vin_bus_master.sv
// Directed bench for vin_bus_master with a small behavioural EF9341 (GEN)
// model on the shared bus; per-cycle traces are compared to hand values.
module tb_vin_bus_master;

  logic       clk = 1'b0;
  logic       rst;
  logic       req_valid;
  logic       req_ready;
  logic [2:0] req_cmd;
  logic [7:0] req_a, req_b;
  logic [3:0] req_adr;
  logic       done, err;
  logic [7:0] rdata_a, rdata_b;
  logic       gen_busy;
  wire  [7:0] busA, busB;
  logic       r_wi, sm_n, sg_n, st_n;
  logic [3:0] adr;
  logic       ve_n;

  int n_total = 0;
  int n_bad   = 0;

  always #5 clk = ~clk;

  vin_bus_master dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready),
    .req_cmd(req_cmd), .req_a(req_a), .req_b(req_b), .req_adr(req_adr),
    .done(done), .err(err), .rdata_a(rdata_a), .rdata_b(rdata_b),
    .gen_busy(gen_busy), .busA(busA), .busB(busB), .r_wi(r_wi),
    .sm_n(sm_n), .sg_n(sg_n), .st_n(st_n), .adr(adr), .ve_n(ve_n)
  );

  // GEN model: char-code latch, slice ROM, mailbox TA/TB.
  logic [7:0] gen_code = 8'h00;
  logic       gen_sel  = 1'b0;
  logic [7:0] gen_ta   = 8'h12;
  logic [7:0] gen_tb   = 8'h34;
  logic       prev_sm  = 1'b1;
  logic       prev_sg  = 1'b1;
  logic       gen_drv_a, gen_drv_b;
  logic [7:0] gen_rom, gen_out_a;

  assign gen_rom   = (gen_code == 8'h85 && adr == 4'd3) ? 8'h5A : 8'h00;
  assign gen_drv_a = (!sg_n && st_n && r_wi) || (!st_n && !r_wi);
  assign gen_drv_b = !st_n && !r_wi;
  assign gen_out_a = st_n ? gen_rom : gen_ta;
  assign busA = gen_drv_a ? gen_out_a : 8'hzz;
  assign busB = gen_drv_b ? gen_tb : 8'hzz;

  always @(negedge clk) begin
    if (!rst) begin
      if (prev_sm && !sm_n) begin
        if (st_n) begin
          gen_code <= {busA[7], busB[6:0]};
          gen_sel  <= busA[7];
        end else if (r_wi) begin
          gen_ta <= busA;
          gen_tb <= busB;
        end
      end
      if (prev_sg && !sg_n && !st_n && r_wi) begin
        gen_ta <= busA;
        gen_tb <= busB;
      end
    end
    prev_sm <= rst ? 1'b1 : sm_n;
    prev_sg <= rst ? 1'b1 : sg_n;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Per-cycle traces; bit i = cycle i+1 after the accepting edge.
  logic [7:0] t_sm, t_sg, t_st, t_rw, t_done, t_rdy, t_a, t_b, t_adr;
  logic       t_err;
  logic [7:0] t_rda, t_rdb;

  task automatic run_cmd(input logic [2:0] cmd, input logic [7:0] a, input logic [7:0] b,
                         input logic [3:0] ad);
    check("ready_before_cmd", req_ready, 1);
    req_cmd = cmd; req_a = a; req_b = b; req_adr = ad; req_valid = 1'b1;
    {t_sm, t_sg, t_st, t_rw, t_done, t_rdy, t_a, t_b, t_adr} = '0;
    t_err = 1'bx; t_rda = 8'hxx; t_rdb = 8'hxx;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (i == 0) req_valid = 1'b0;
      t_sm[i]   = !sm_n;
      t_sg[i]   = !sg_n;
      t_st[i]   = !st_n;
      t_rw[i]   = !r_wi;
      t_done[i] = done;
      t_rdy[i]  = req_ready;
      t_a[i]    = (busA === a);
      t_b[i]    = (busB === b);
      t_adr[i]  = (adr === ad);
      if (done) begin
        t_err = err; t_rda = rdata_a; t_rdb = rdata_b;
      end
    end
  endtask

  logic [15:0] b_done, b_err, b_rdy, b_sm, b_sg;
  logic        d_seen;

  initial begin
    rst = 1'b1; req_valid = 1'b0; req_cmd = 3'd0; req_a = 8'h00; req_b = 8'h00;
    req_adr = 4'd0; ve_n = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_sm_n", sm_n, 1);
    check("rst_sg_n", sg_n, 1);
    check("rst_st_n", st_n, 1);
    check("rst_r_wi", r_wi, 1);
    check("rst_adr", adr, 0);
    check("rst_done", done, 0);
    check("rst_err", err, 0);
    check("rst_rdata", {rdata_a, rdata_b}, 0);
    check("rst_gen_busy", gen_busy, 0);
    check("rst_ready", req_ready, 1);
    rst = 1'b0;
    @(negedge clk);

    // CHAR a=0x81 b=0x05
    run_cmd(3'd0, 8'h81, 8'h05, 4'd0);
    check("char_sm_low", t_sm, 8'h0E);
    check("char_sg_low", t_sg, 8'h00);
    check("char_st_low", t_st, 8'h00);
    check("char_rw_low", t_rw, 8'h00);
    check("char_busA", t_a, 8'h1F);
    check("char_busB", t_b, 8'h1F);
    check("char_done", t_done, 8'h20);
    check("char_ready", t_rdy, 8'h80);
    check("char_err", t_err, 0);
    check("gen_code", gen_code, 8'h85);
    check("gen_sel", gen_sel, 1);

    // SLICE adr=3; master data 0xC3/0x3C must never reach the bus
    run_cmd(3'd1, 8'hC3, 8'h3C, 4'd3);
    check("slice_sg_low", t_sg, 8'h0E);
    check("slice_sm_low", t_sm, 8'h00);
    check("slice_st_low", t_st, 8'h00);
    check("slice_busA_rel", t_a, 8'h00);
    check("slice_busB_rel", t_b, 8'h00);
    check("slice_adr", t_adr, 8'h1F);
    check("slice_done", t_done, 8'h20);
    check("slice_rdata_a", t_rda, 8'h5A);
    check("slice_err", t_err, 0);

    // MBX_RD from TA=0x12 TB=0x34
    run_cmd(3'd2, 8'h99, 8'h66, 4'd0);
    check("rd_st_low", t_st, 8'h1F);
    check("rd_rw_low", t_rw, 8'h1F);
    check("rd_strobes", {t_sm, t_sg}, 16'h0000);
    check("rd_busA_rel", t_a, 8'h00);
    check("rd_done", t_done, 8'h20);
    check("rd_rdata_a", t_rda, 8'h12);
    check("rd_rdata_b", t_rdb, 8'h34);

    // gen_busy falls two clocks after ve_n rises
    check("busy_high", gen_busy, 1);
    ve_n = 1'b1;
    @(negedge clk);
    check("busy_sync_1", gen_busy, 1);
    @(negedge clk);
    check("busy_sync_2", gen_busy, 0);

    // MBX_WR_G a=0xAA b=0x55
    run_cmd(3'd4, 8'hAA, 8'h55, 4'd0);
    check("wrg_st_low", t_st, 8'h1F);
    check("wrg_sg_low", t_sg, 8'h0E);
    check("wrg_sm_low", t_sm, 8'h00);
    check("wrg_rw_low", t_rw, 8'h00);
    check("wrg_busA", t_a, 8'h1F);
    check("wrg_busB", t_b, 8'h1F);
    check("wrg_done", t_done, 8'h20);
    check("wrg_gen_ta", gen_ta, 8'hAA);
    check("wrg_gen_tb", gen_tb, 8'h55);
    check("wrg_rdata_kept", {rdata_a, rdata_b}, 16'h1234);

    // Illegal cmd 7 then CHAR with req_valid held high
    {b_done, b_err, b_rdy, b_sm, b_sg} = '0;
    req_cmd = 3'd7; req_a = 8'h00; req_b = 8'h00; req_valid = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (i == 0) begin req_cmd = 3'd0; req_a = 8'h81; req_b = 8'h05; end
      if (i == 3) req_valid = 1'b0;
      b_done[i] = done;
      b_err[i]  = done & err;
      b_rdy[i]  = req_ready;
      b_sm[i]   = !sm_n;
      b_sg[i]   = !sg_n;
    end
    check("b2b_done", b_done, 16'h0101);
    check("b2b_err", b_err, 16'h0001);
    check("b2b_ready", b_rdy, 16'h0004);
    check("b2b_sm_low", b_sm, 16'h0070);
    check("b2b_sg_low", b_sg, 16'h0000);
    @(negedge clk);
    check("b2b_idle_again", req_ready, 1);

    // Reset on the 2nd STROBE clock of MBX_WR_M
    req_cmd = 3'd3; req_a = 8'h11; req_b = 8'h22; req_valid = 1'b1;
    @(negedge clk);
    req_valid = 1'b0;
    repeat (2) @(negedge clk);
    check("wrm_sm_low", sm_n, 0);
    rst = 1'b1;
    @(negedge clk);
    check("abort_sm_n", sm_n, 1);
    check("abort_st_n", st_n, 1);
    check("abort_r_wi", r_wi, 1);
    check("abort_busA_rel", busA === 8'h11, 0);
    check("abort_busB_rel", busB === 8'h22, 0);
    check("abort_done", done, 0);
    rst = 1'b0;
    d_seen = 1'b0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      d_seen = d_seen | done;
    end
    check("abort_no_done", d_seen, 0);
    check("abort_ready", req_ready, 1);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule

// File: doc/vin_bus_master.md
Name: vin_bus_master

Overview:
- Initiator side of the EF9340 (VIN) / EF9341 (GEN) internal bus: `busA`, `busB`, `r_wi`, `sm_n`, `sg_n`, `st_n`, `adr`, `ve_n`.
- Accepts one bus-cycle command at a time from the VIN display/command logic and generates that cycle's strobe sequence. Supported cycles: character-code load, slice fetch, mailbox read, mailbox write via `sm_n`, mailbox write via `sg_n`.
- Returns sampled bus data and a one-clock completion pulse.
- Strobe timing satisfies the GEN's double-latched falling-edge detection: a strobe must be high for at least 2 clocks before it falls, and low for at least 2 clocks.

Parameters:
SETUP_CYC, 1, clocks that bus/`st_n`/`r_wi`/`adr` are valid before the strobe falls (≥1)
STROBE_CYC, 3, clocks the strobe is held low (≥3; the GEN updates its output on the 2nd low clock)
HOLD_CYC, 1, clocks that bus/`st_n`/`r_wi` are held after the strobe rises (≥1)
GAP_CYC, 2, idle clocks with all strobes high before the next command (≥2)

Ports:
clk  input  1  system clock, 14 MHz nominal
rst  input  1  synchronous active-high reset
req_valid  input  1  command request
req_ready  output  1  high in IDLE only; accept = req_valid & req_ready
req_cmd  input  3  0 CHAR, 1 SLICE, 2 MBX_RD, 3 MBX_WR_M, 4 MBX_WR_G, 5-7 illegal
req_a  input  8  data driven on busA (CHAR, MBX_WR_*)
req_b  input  8  data driven on busB (CHAR, MBX_WR_*)
req_adr  input  4  slice row for SLICE
done  output  1  one-clock completion pulse
err  output  1  valid with done; 1 = illegal command
rdata_a  output  8  busA sample (SLICE, MBX_RD)
rdata_b  output  8  busB sample (MBX_RD)
gen_busy  output  1  ~ve_n after a 2-flop synchroniser
busA  inout  8  internal bus A
busB  inout  8  internal bus B
r_wi  output  1  internal read/write
sm_n  output  1  memory strobe, active low
sg_n  output  1  generator strobe, active low
st_n  output  1  transfer select, active low
adr  output  4  slice address
ve_n  input  1  GEN busy, active low

Behaviour:

Reset (and idle) values:
- State IDLE; `sm_n`=`sg_n`=`st_n`=1; `r_wi`=1; `adr`=0; `busA`/`busB` high-Z.
- `done`=0, `err`=0, `rdata_a`=0, `rdata_b`=0, `gen_busy`=0.
- Reset asserted mid-cycle: all of the above are forced on the next edge. No completion pulse is emitted for the aborted command.

States:
- IDLE: `req_ready`=1.
  - On accept: latch cmd/a/b/adr.
  - Legal command → SETUP.
  - Illegal command → GAP, with `done`=1 and `err`=1 on the next clock and no strobe activity.
- SETUP (SETUP_CYC clocks): drive the command's static signals (list below); strobes remain high → STROBE.
- STROBE (STROBE_CYC clocks): static signals unchanged.
  - The selected strobe is low: `sm_n` for CHAR and MBX_WR_M, `sg_n` for SLICE and MBX_WR_G, none for MBX_RD (`st_n` low is the transfer).
  - On the last STROBE clock edge: SLICE latches `rdata_a` from busA; MBX_RD latches `rdata_a` and `rdata_b`.
  - → HOLD.
- HOLD (HOLD_CYC clocks): strobe high; static signals and bus drive unchanged → GAP.
- GAP (GAP_CYC clocks): everything at idle values.
  - `done`=1 on the first GAP clock; `err`=0 for legal commands.
  - → IDLE.

Static signals per command:
- CHAR: `r_wi`=1, `st_n`=1, drive busA=req_a, busB=req_b.
- SLICE: `r_wi`=1, `st_n`=1, `adr`=req_adr, buses released.
- MBX_RD: `r_wi`=0, `st_n`=0, buses released.
- MBX_WR_M, MBX_WR_G: `r_wi`=1, `st_n`=0, drive busA=req_a, busB=req_b.

Timing:
- Accept to `done` = 1+SETUP_CYC+STROBE_CYC+HOLD_CYC clocks (6 with defaults).
- Accept to next `req_ready` = that + GAP_CYC clocks (8 with defaults).
- Illegal command: `done` 1 clock after accept; `req_ready` again after GAP_CYC clocks.

Other rules:
- Never drive busA/busB in any cycle where the GEN may drive them: SLICE, MBX_RD, IDLE, GAP.
- At most one strobe is low at any time. `sm_n` and `sg_n` are never simultaneously low.
- `rdata_*` hold their value until the next SLICE or MBX_RD completes. Other commands leave them unchanged.
- `req_valid` outside IDLE is ignored; no queuing.
- `gen_busy` is independent of the FSM; commands are not blocked on it.
- Counters are 4 bits; parameters must be ≤15.

Test Plan:
- Reset, then CHAR a=0x81, b=0x05 → `sm_n` low on clocks 2-4 after accept, busA=0x81/busB=0x05 on clocks 1-5, `st_n`=1, `done` on clock 6; a GEN model latches code 0x85, Gen_Selected=1.
- SLICE adr=3 after that CHAR, GEN ROM[0x85*10+3]=0x5A → `sg_n` low for 3 clocks, busA released by the master, `rdata_a`=0x5A at `done`.
- MBX_RD with GEN mailbox TA=0x12, TB=0x34, ve_n=0 → `st_n`=0 and `r_wi`=0 for 5 clocks, no strobe, `rdata_a`=0x12, `rdata_b`=0x34; `gen_busy` goes 1→0 two clocks after ve_n rises.
- MBX_WR_G a=0xAA, b=0x55 → `st_n`=0, `sg_n` low for 3 clocks, GEN TA=0xAA, TB=0x55; `rdata_*` unchanged from the previous read.
- Back-to-back `req_valid` held high with cmds 7 then CHAR → `done`=1 with `err`=1 one clock after the first accept, no strobes, CHAR accepted exactly GAP_CYC clocks later.
- Reset asserted on the 2nd STROBE clock of MBX_WR_M → next edge: `sm_n`=`st_n`=1, buses Z, no `done` pulse, `req_ready`=1 after reset deasserts.
